// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer for the 3-phase motor PWM datapath.
// Produces the step index, the in-step counter and the boundary strobes. All state changes on the falling clock edge.
module motoro3_step_sequencer #(
    parameter int STEP_NUM = 12,
    parameter int CNT_W    = 25,
    parameter int MIN_LEN  = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] stepLen,
    output logic             pwmActive1,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst2,
    output logic             m3cntFirst1,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic [15:0]      roundCnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C     = CNT_W'(2);
    localparam logic [3:0]       LAST_STEP = 4'(STEP_NUM - 1);

    state_t           state;
    logic [CNT_W-1:0] lenLat;
    logic [CNT_W-1:0] clampLen;
    logic             inRun;
    logic             stepEnd;

    assign clampLen = (stepLen < MIN_LEN_C) ? MIN_LEN_C : stepLen;
    assign inRun    = (state == RUN);
    assign stepEnd  = inRun && (m3cnt == lenLat - ONE_C);

    // Strobes are pure decodes; lenLat >= 4 keeps all four on distinct cycles.
    assign m3cntFirst2 = inRun && (m3cnt == '0);
    assign m3cntFirst1 = inRun && (m3cnt == ONE_C);
    assign m3cntLast2  = inRun && (m3cnt == lenLat - TWO_C);
    assign m3cntLast1  = stepEnd;

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            pwmActive1 <= 1'b0;
            sgStep     <= '0;
            m3cnt      <= '0;
            roundCnt   <= '0;
            busy       <= 1'b0;
            lenLat     <= MIN_LEN_C;
        end else begin
            case (state)
                IDLE: begin
                    pwmActive1 <= 1'b0;
                    m3cnt      <= '0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    lenLat     <= clampLen;
                    m3cnt      <= '0;
                    pwmActive1 <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    if (stepEnd) begin
                        // The step index advances even when stopping, so a restart resumes on the next step.
                        m3cnt <= '0;
                        if (sgStep == LAST_STEP) begin
                            sgStep   <= '0;
                            roundCnt <= roundCnt + 16'd1;
                        end else begin
                            sgStep <= sgStep + 4'd1;
                        end
                        if (stop) begin
                            state      <= DRAIN;
                            pwmActive1 <= 1'b0;
                        end else begin
                            lenLat <= clampLen;
                        end
                    end else begin
                        m3cnt <= m3cnt + ONE_C;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed self-checking bench for motoro3_step_sequencer.
// Inputs change just after posedge and outputs are sampled on posedge, half a cycle away from the active negedge.
module tb_motoro3_step_sequencer;

    logic        clk;
    logic        nRst;
    logic        start;
    logic        stop;
    logic [24:0] stepLen;
    logic        pwmActive1;
    logic [3:0]  sgStep;
    logic [24:0] m3cnt;
    logic        m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1;
    logic [15:0] roundCnt;
    logic        busy;

    int nChecks = 0;
    int nFails  = 0;

    motoro3_step_sequencer dut (
        .clk(clk), .nRst(nRst), .start(start), .stop(stop), .stepLen(stepLen),
        .pwmActive1(pwmActive1), .sgStep(sgStep), .m3cnt(m3cnt),
        .m3cntFirst2(m3cntFirst2), .m3cntFirst1(m3cntFirst1),
        .m3cntLast2(m3cntLast2), .m3cntLast1(m3cntLast1),
        .roundCnt(roundCnt), .busy(busy)
    );

    initial begin
        clk = 1'b1;
        forever #50 clk = ~clk;
    end

    function automatic logic [50:0] snap();
        return {pwmActive1, busy, sgStep, m3cnt,
                m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1, roundCnt};
    endfunction

    function automatic logic [50:0] mk(input logic pwm, input logic bsy, input int step,
                                       input int cnt, input logic [3:0] strb, input int rnd);
        return {pwm, bsy, 4'(step), 25'(cnt), strb, 16'(rnd)};
    endfunction

    // Expected strobe pattern {First2, First1, Last2, Last1} for a RUN cycle.
    function automatic logic [3:0] strobesFor(input int cnt, input int len);
        return {cnt == 0, cnt == 1, cnt == len - 2, cnt == len - 1};
    endfunction

    task automatic test_reset();
        nRst = 1'b0; start = 1'b0; stop = 1'b0; stepLen = 25'd10;
        repeat (2) @(posedge clk);
        nChecks++;
        if (snap() !== mk(0, 0, 0, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL reset_state actual=%h expected=%h", snap(), mk(0, 0, 0, 0, 4'b0000, 0));
        end
        nRst = 1'b1;
        @(posedge clk);
        nChecks++;
        if (snap() !== mk(0, 0, 0, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL idle_after_reset actual=%h expected=%h", snap(), mk(0, 0, 0, 0, 4'b0000, 0));
        end
    endtask

    task automatic test_basic_step();
        start = 1'b1; stepLen = 25'd10;
        @(posedge clk);
        nChecks++;
        if (snap() !== mk(0, 1, 0, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL load_cycle actual=%h expected=%h", snap(), mk(0, 1, 0, 0, 4'b0000, 0));
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(1, 1, 0, i, strobesFor(i, 10), 0)) begin
                nFails++;
                $display("[TB] FAIL basic_step cnt=%0d actual=%h expected=%h", i, snap(), mk(1, 1, 0, i, strobesFor(i, 10), 0));
            end
        end
    endtask

    task automatic test_len_change();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(1, 1, 1, i, strobesFor(i, 10), 0)) begin
                nFails++;
                $display("[TB] FAIL len_change_old cnt=%0d actual=%h expected=%h", i, snap(), mk(1, 1, 1, i, strobesFor(i, 10), 0));
            end
            if (i == 3) stepLen = 25'd20;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(1, 1, 2, i, strobesFor(i, 20), 0)) begin
                nFails++;
                $display("[TB] FAIL len_change_new cnt=%0d actual=%h expected=%h", i, snap(), mk(1, 1, 2, i, strobesFor(i, 20), 0));
            end
            if (i == 0) stepLen = 25'd2;
        end
    endtask

    task automatic test_clamp();
        logic [3:0] expStrb [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(1, 1, 3, i, expStrb[i], 0)) begin
                nFails++;
                $display("[TB] FAIL clamp_len4 cnt=%0d actual=%h expected=%h", i, snap(), mk(1, 1, 3, i, expStrb[i], 0));
            end
            if (i == 0) stepLen = 25'd8;
        end
    endtask

    task automatic test_stop_drain();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(1, 1, 4, i, strobesFor(i, 8), 0)) begin
                nFails++;
                $display("[TB] FAIL stop_completes cnt=%0d actual=%h expected=%h", i, snap(), mk(1, 1, 4, i, strobesFor(i, 8), 0));
            end
            if (i == 2) begin
                stop = 1'b1;
                start = 1'b1;
            end
        end
        start = 1'b0;
        @(posedge clk);
        nChecks++;
        if (snap() !== mk(0, 1, 5, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL drain_cycle actual=%h expected=%h", snap(), mk(0, 1, 5, 0, 4'b0000, 0));
        end
        stop = 1'b0;
        repeat (2) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(0, 0, 5, 0, 4'b0000, 0)) begin
                nFails++;
                $display("[TB] FAIL idle_hold actual=%h expected=%h", snap(), mk(0, 0, 5, 0, 4'b0000, 0));
            end
        end
        stepLen = 25'd5; start = 1'b1;
        @(posedge clk);
        nChecks++;
        if (snap() !== mk(0, 1, 5, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL restart_load actual=%h expected=%h", snap(), mk(0, 1, 5, 0, 4'b0000, 0));
        end
        start = 1'b0;
    endtask

    task automatic test_rounds();
        int step = 5;
        int rnd  = 0;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                nChecks++;
                if (snap() !== mk(1, 1, step, i, strobesFor(i, 5), rnd)) begin
                    nFails++;
                    $display("[TB] FAIL rounds step=%0d cnt=%0d actual=%h expected=%h", step, i, snap(), mk(1, 1, step, i, strobesFor(i, 5), rnd));
                end
                if (k == 19 && i == 0) stepLen = 25'd10;
            end
            if (step == 11) begin
                step = 0;
                rnd++;
            end else begin
                step++;
            end
        end
    endtask

    task automatic test_reset_midstep();
        bit found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk);
            if (sgStep == 4'd7 && m3cnt == 25'd5) found = 1'b1;
        end
        nChecks++;
        if (!found) begin
            nFails++;
            $display("[TB] FAIL reach_step7_cnt5 actual=step%0d/cnt%0d required=step7/cnt5", sgStep, m3cnt);
        end
        #10 nRst = 1'b0;
        #1;
        nChecks++;
        if (snap() !== mk(0, 0, 0, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL async_reset actual=%h expected=%h", snap(), mk(0, 0, 0, 0, 4'b0000, 0));
        end
        repeat (5) begin
            @(posedge clk);
            nChecks++;
            if (snap() !== mk(0, 0, 0, 0, 4'b0000, 0)) begin
                nFails++;
                $display("[TB] FAIL no_partial_strobes actual=%h expected=%h", snap(), mk(0, 0, 0, 0, 4'b0000, 0));
            end
        end
        nRst = 1'b1;
        @(posedge clk);
        nChecks++;
        if (snap() !== mk(0, 0, 0, 0, 4'b0000, 0)) begin
            nFails++;
            $display("[TB] FAIL idle_after_release actual=%h expected=%h", snap(), mk(0, 0, 0, 0, 4'b0000, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_len_change();
        test_clamp();
        test_stop_drain();
        test_rounds();
        test_reset_midstep();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
